neuron_scheduler: RTL and testbench
===================================

Name: neuron_scheduler

Overview:
Time-multiplexes one pipelined neuron core across N_NEURONS neurons. The block holds the per-neuron state (v, w) and input-current (i) register files. On each start it issues every neuron to the core, one per cycle, in ascending address order. It writes the core results back, flags spikes on rising threshold crossings of v, and pulses done when the timestep completes. It sits between the host/event interface and the single neuron core instance.

Parameters:
N_NEURONS, 16, number of neurons sharing the core (at least 2).
ADDR_W, 4, neuron address width, equal to clog2(N_NEURONS).
W, 16, fixed-point word width (Q3.12: 1 sign, 3 integer, 12 fraction bits).
CORE_LAT, 4, core latency in clock edges from input sampling to v_out/w_out valid.
V_INIT, 16'hECE1, v value loaded into every neuron at initialisation.
W_INIT, 16'hF600, w value loaded into every neuron at initialisation.
SPIKE_TH, 16'sh1000, spike threshold for v (+1.0).

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request one timestep; honoured only in IDLE.
busy  out  1  high from acceptance of start until done.
done  out  1  one-cycle pulse at timestep completion.
i_wr_en  in  1  input-current write strobe.
i_wr_addr  in  ADDR_W  neuron address for the current write.
i_wr_data  in  W  signed current value.
core_i  out  W  current presented to the core.
core_v  out  W  v presented to the core.
core_w  out  W  w presented to the core.
core_v_out  in  W  v result from the core.
core_w_out  in  W  w result from the core.
spike_valid  out  1  one-cycle spike event strobe.
spike_addr  out  ADDR_W  address of the neuron that spiked.
step_count  out  32  number of completed timesteps.

Behaviour:
- Reset values (asynchronous): state=INIT, busy=0, done=0, spike_valid=0, spike_addr=0, step_count=0, core_i/core_v/core_w=0, tag pipeline valid bits=0, i file all zero.
- FSM states: INIT, IDLE, ISSUE, DRAIN.
- INIT: writes V_INIT/W_INIT to entries 0..N_NEURONS-1, one per cycle. Moves to IDLE after the last entry. start is ignored in INIT; busy=1 during INIT.
- IDLE: if start is sampled at edge S, go to ISSUE with idx=0 and busy=1.
- ISSUE: at edges S+1..S+N_NEURONS, register core_v/core_w/core_i from entry idx, push tag {valid, idx, v_old} into the tag pipeline, and increment idx. After idx=N_NEURONS-1 is issued, go to DRAIN.
- Tag pipeline depth is CORE_LAT+1. Neuron k, issued at edge S+1+k, is written back at edge S+k+CORE_LAT+2 (S+k+6 at the default) from core_v_out/core_w_out.
- Spike check at writeback: the spike condition is (v_old < SPIKE_TH) and (new v >= SPIKE_TH), both compared signed. When true, spike_valid=1 and spike_addr=k for exactly one cycle, registered on the writeback edge. At most one spike per cycle.
- DRAIN: waits for the last writeback. On that edge (S+N_NEURONS+CORE_LAT+1): done=1 for one cycle, busy=0, step_count+1, state goes to IDLE.
- The default start-to-done latency is N_NEURONS+5 edges (21 for N=16). A new start is accepted on the edge after done.
- start while busy or in INIT: ignored, not queued.
- i writes are accepted in every state. A write to the entry being read on the same edge: the read returns the old value and the new value applies next timestep.
- The v/w files are written only by INIT and writeback. There is no read/write hazard, because every read of a timestep precedes every writeback of that timestep.
- step_count wraps modulo 2^32.
- core_* outputs hold their last issued values outside ISSUE. The core is not reset by this block; results emerging with no valid tag are ignored.
- Reset mid-step aborts immediately: in-flight tags are discarded, no done and no spikes are produced, and the block re-runs INIT.

Decomposition:
- Package neuron_pkg holds: W, the Q3.12 typedef fix_t, V_INIT, W_INIT, SPIKE_TH, and the tag struct {valid, addr, v_old}.
- One natural sub-module, neuron_state_ram: dual v/w register file with one combinational read port and one write port, plus a mux between INIT writes and writeback writes.

Test Plan:
- Reset release -> busy=1 for 16 cycles (INIT), then IDLE. First start: core_v=16'hECE1 and core_w=16'hF600 for all 16 issues.
- i file all 0, start at edge S -> done exactly at edge S+21, step_count=1. Written-back v/w equal the bit-exact core model for every neuron.
- Neuron 5 driven with i=16'sh3000 over repeated steps -> exactly one spike_valid with spike_addr=5 on the step where v first reaches >=16'sh1000. No spike on later steps while v stays above threshold.
- start held high through a whole step -> a second step starts only after done. Exactly one done per step; step_count increments by 1 per step.
- i_wr to addr 3 on the same edge neuron 3 is issued -> core_i holds the old value. The next step uses the new value.
- rst asserted at issue of neuron 7 -> immediate reset values, no done, no spike_valid. INIT reruns and all entries are restored to V_INIT/W_INIT.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed neuron scheduler.
// Q3.12 fixed-point words: 1 sign, 3 integer and 12 fraction bits.
package neuron_pkg;
    localparam int W          = 16;
    localparam int TAG_ADDR_W = 8;

    typedef logic signed [W-1:0] fix_t;

    localparam fix_t V_INIT   = 16'hECE1;
    localparam fix_t W_INIT   = 16'hF600;
    localparam fix_t SPIKE_TH = 16'sh1000;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    // Travels alongside each neuron through the core so writeback knows its target.
    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] addr;
        fix_t                  v_old;
    } tag_t;
endpackage

// File: rtl/neuron_state_ram.sv
// Per-neuron v/w register file: one combinational read port, one write port
// shared between initialisation fill and core writeback (fill has priority).
module neuron_state_ram
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [W-1:0]      wb_v,
    input  logic [W-1:0]      wb_w,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_v,
    output logic [W-1:0]      rd_w
);
    fix_t              v_mem_q [N_NEURONS];
    fix_t              v_mem_d [N_NEURONS];
    fix_t              w_mem_q [N_NEURONS];
    fix_t              w_mem_d [N_NEURONS];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    fix_t              wr_v;
    fix_t              wr_w;

    always_comb begin
        wr_en   = init_en | wb_en;
        wr_addr = init_en ? init_addr : wb_addr;
        wr_v    = init_en ? V_INIT : fix_t'(wb_v);
        wr_w    = init_en ? W_INIT : fix_t'(wb_w);
        v_mem_d = v_mem_q;
        w_mem_d = w_mem_q;
        if (wr_en) begin
            v_mem_d[wr_addr] = wr_v;
            w_mem_d[wr_addr] = wr_w;
        end
    end

    // Contents are defined by the fill sequence after reset, so no reset here.
    always_ff @(posedge clk) begin
        v_mem_q <= v_mem_d;
        w_mem_q <= w_mem_d;
    end

    assign rd_v = v_mem_q[rd_addr];
    assign rd_w = w_mem_q[rd_addr];
endmodule

// File: rtl/neuron_scheduler.sv
// Issues every neuron to one shared pipelined core per timestep, writes results
// back, flags rising threshold crossings; start-to-done is N_NEURONS+CORE_LAT+1 edges.
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4,
    parameter int CORE_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [W-1:0]      i_wr_data,
    output logic [W-1:0]      core_i,
    output logic [W-1:0]      core_v,
    output logic [W-1:0]      core_w,
    input  logic [W-1:0]      core_v_out,
    input  logic [W-1:0]      core_w_out,
    output logic              spike_valid,
    output logic [ADDR_W-1:0] spike_addr,
    output logic [31:0]       step_count
);
    localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(N_NEURONS - 1);
    localparam logic [TAG_ADDR_W-1:0] LAST_TAG = TAG_ADDR_W'(N_NEURONS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              spike_valid_q, spike_valid_d;
    logic [ADDR_W-1:0] spike_addr_q, spike_addr_d;
    logic [31:0]       step_count_q, step_count_d;
    fix_t              core_i_q, core_i_d;
    fix_t              core_v_q, core_v_d;
    fix_t              core_w_q, core_w_d;
    tag_t              tag_q [CORE_LAT+1];
    tag_t              tag_d [CORE_LAT+1];
    fix_t              i_file_q [N_NEURONS];
    fix_t              i_file_d [N_NEURONS];

    tag_t              wb_tag;
    logic [W-1:0]      ram_rd_v;
    logic [W-1:0]      ram_rd_w;

    assign wb_tag = tag_q[CORE_LAT];

    neuron_state_ram #(
        .N_NEURONS (N_NEURONS),
        .ADDR_W    (ADDR_W)
    ) u_state_ram (
        .clk       (clk),
        .init_en   (state_q == ST_INIT),
        .init_addr (idx_q),
        .wb_en     (wb_tag.valid),
        .wb_addr   (wb_tag.addr[ADDR_W-1:0]),
        .wb_v      (core_v_out),
        .wb_w      (core_w_out),
        .rd_addr   (idx_q),
        .rd_v      (ram_rd_v),
        .rd_w      (ram_rd_w)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        spike_valid_d = 1'b0;
        spike_addr_d  = spike_addr_q;
        step_count_d  = step_count_q;
        core_i_d      = core_i_q;
        core_v_d      = core_v_q;
        core_w_d      = core_w_q;
        i_file_d      = i_file_q;

        // Reads below use i_file_q, so a same-edge write lands next timestep.
        if (i_wr_en) begin
            i_file_d[i_wr_addr] = fix_t'(i_wr_data);
        end

        tag_d[0] = '0;
        for (int j = 1; j <= CORE_LAT; j++) begin
            tag_d[j] = tag_q[j-1];
        end

        if (wb_tag.valid && ($signed(wb_tag.v_old) < $signed(SPIKE_TH)) &&
            ($signed(core_v_out) >= $signed(SPIKE_TH))) begin
            spike_valid_d = 1'b1;
            spike_addr_d  = wb_tag.addr[ADDR_W-1:0];
        end

        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_i_d       = i_file_q[idx_q];
                core_v_d       = fix_t'(ram_rd_v);
                core_w_d       = fix_t'(ram_rd_w);
                tag_d[0].valid = 1'b1;
                tag_d[0].addr  = TAG_ADDR_W'(idx_q);
                tag_d[0].v_old = fix_t'(ram_rd_v);
                idx_d          = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_tag.valid && (wb_tag.addr == LAST_TAG)) begin
                    done_d       = 1'b1;
                    step_count_d = step_count_q + 32'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Held through the final fill cycle so busy spans the whole fill.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_addr_q  <= '0;
            step_count_q  <= '0;
            core_i_q      <= '0;
            core_v_q      <= '0;
            core_w_q      <= '0;
            for (int j = 0; j <= CORE_LAT; j++) begin
                tag_q[j] <= '0;
            end
            for (int n = 0; n < N_NEURONS; n++) begin
                i_file_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spike_valid_q <= spike_valid_d;
            spike_addr_q  <= spike_addr_d;
            step_count_q  <= step_count_d;
            core_i_q      <= core_i_d;
            core_v_q      <= core_v_d;
            core_w_q      <= core_w_d;
            tag_q         <= tag_d;
            i_file_q      <= i_file_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_valid = spike_valid_q;
    assign spike_addr  = spike_addr_q;
    assign step_count  = step_count_q;
    assign core_i      = core_i_q;
    assign core_v      = core_v_q;
    assign core_w      = core_w_q;
endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with a 4-stage reference core attached:
// v' = sat(v + i/4), w' = w + 0x0010.
module tb_neuron_scheduler;
    import neuron_pkg::*;

    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int PER = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [15:0]   i_wr_data;
    logic [15:0]   core_i, core_v, core_w;
    logic [15:0]   core_v_out, core_w_out;
    logic          spike_valid;
    logic [AW-1:0] spike_addr;
    logic [31:0]   step_count;

    int            checks;
    int            failures;
    int            exp_steps;
    int            nspk;
    int            last_spk;
    logic [15:0]   obs_v5;
    logic [15:0]   obs_i3;
    logic [15:0]   v_m [N];
    logic [15:0]   w_m [N];
    logic [15:0]   i_m [N];
    bit            exp_spk [N];
    logic [15:0]   pv [4];
    logic [15:0]   pw [4];

    always #5 clk = ~clk;

    neuron_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .CORE_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .core_i      (core_i),
        .core_v      (core_v),
        .core_w      (core_w),
        .core_v_out  (core_v_out),
        .core_w_out  (core_w_out),
        .spike_valid (spike_valid),
        .spike_addr  (spike_addr),
        .step_count  (step_count)
    );

    function automatic logic [15:0] core_fv(input logic [15:0] v, input logic [15:0] i);
        logic signed [16:0] a, b, s;
        a = {v[15], v};
        b = {i[15], i};
        b = b >>> 2;
        s = a + b;
        if (s > 17'sd32767) return 16'h7FFF;
        if (s < -17'sd32768) return 16'h8000;
        return s[15:0];
    endfunction

    always @(posedge clk) begin
        pv[0] <= core_fv(core_v, core_i);
        pw[0] <= core_w + 16'h0010;
        for (int j = 1; j < 4; j++) begin
            pv[j] <= pv[j-1];
            pw[j] <= pw[j-1];
        end
    end
    assign core_v_out = pv[3];
    assign core_w_out = pw[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            v_m[k] = V_INIT;
            w_m[k] = W_INIT;
            i_m[k] = 16'h0000;
        end
        exp_steps = 0;
    endtask

    task automatic wr_i(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        @(negedge clk);
        i_wr_en = 1'b0;
        i_m[a] = d;
    endtask

    // Runs n back-to-back timesteps; hold keeps start high throughout. A current
    // write can be scheduled to land on edge S+wr_c (wr_c=0 disables it).
    task automatic run_steps(input int n, input bit hold, input int wr_c,
                             input logic [AW-1:0] wa, input logic [15:0] wd);
        nspk = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= n * PER; c++) begin
            int s, r, k;
            logic [15:0] nv;
            @(negedge clk);
            s = (c - 1) / PER;
            r = c - s * PER;
            if (r >= 1 && r <= N) begin
                k = r - 1;
                chk("issue_v", core_v, v_m[k]);
                chk("issue_w", core_w, w_m[k]);
                chk("issue_i", core_i, i_m[k]);
                if (k == 5) obs_v5 = core_v;
                if (k == 3) obs_i3 = core_i;
                nv = core_fv(v_m[k], i_m[k]);
                exp_spk[k] = ($signed(v_m[k]) < $signed(SPIKE_TH)) && ($signed(nv) >= $signed(SPIKE_TH));
                v_m[k] = nv;
                w_m[k] = w_m[k] + 16'h0010;
            end
            if (r >= 6 && r <= N + 5) begin
                k = r - 6;
                chk("spike_valid", spike_valid, exp_spk[k]);
                if (exp_spk[k]) chk("spike_addr", spike_addr, k);
            end else begin
                chk("spike_quiet", spike_valid, 0);
            end
            if (spike_valid) begin
                nspk++;
                last_spk = spike_addr;
            end
            chk("done", done, r == 21);
            chk("busy", busy, (r < 21) || (r == PER && s + 1 < n));
            chk("step_count", step_count, exp_steps + s + ((r >= 21) ? 1 : 0));
            if (r == 21 && s == n - 1) begin
                start = 1'b0;
                exp_steps += n;
                break;
            end
            if (!hold && r == 9) start = 1'b1;
            if (!hold && r == 10) start = 1'b0;
            if (c == wr_c - 1) begin
                i_wr_en = 1'b1; i_wr_addr = wa; i_wr_data = wd;
            end
            if (c == wr_c) begin
                i_wr_en = 1'b0;
                i_m[wa] = wd;
            end
        end
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
    endtask

    initial begin
        checks = 0; failures = 0; nspk = 0; last_spk = -1;
        rst = 1'b1; start = 1'b0;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike", spike_valid, 0);
        chk("rst_spike_addr", spike_addr, 0);
        chk("rst_steps", step_count, 0);
        chk("rst_core_v", core_v, 0);
        chk("rst_core_w", core_w, 0);
        chk("rst_core_i", core_i, 0);

        // Fill phase: busy for 16 cycles; a start pulse in the middle is dropped.
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("init_busy", busy, c <= 16);
            chk("init_done", done, 0);
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end

        // Step 1: all currents zero, every issue sees the init values.
        run_steps(1, 1'b0, 0, '0, '0);
        chk("first_v5", obs_v5, 16'hECE1);
        chk("first_nspk", nspk, 0);

        // Drive neuron 5 hard: v goes -4895 -> -1823 -> 1249 -> 4321 -> 7393.
        wr_i(4'd5, 16'h3000);
        run_steps(1, 1'b0, 0, '0, '0);
        chk("drive_nspk_early", nspk, 0);
        run_steps(3, 1'b1, 0, '0, '0);
        chk("drive_nspk", nspk, 1);
        chk("drive_spk_addr", last_spk, 5);
        chk("drive_v5_after", obs_v5, 16'h10E1);

        // Current write colliding with the read of neuron 3.
        run_steps(1, 1'b0, 4, 4'd3, 16'h0800);
        chk("collide_old_i3", obs_i3, 16'h0000);
        chk("collide_nspk", nspk, 0);
        run_steps(1, 1'b0, 0, '0, '0);
        chk("collide_new_i3", obs_i3, 16'h0800);
        chk("steps_total", step_count, 7);

        // Reset in the middle of issue: everything aborts and the fill re-runs.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_spike", spike_valid, 0);
        chk("abort_steps", step_count, 0);
        chk("abort_core_v", core_v, 0);
        chk("abort_core_i", core_i, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_done", done, 0);
            chk("abort_hold_spike", spike_valid, 0);
        end
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("reinit_busy", busy, c <= 16);
            chk("reinit_done", done, 0);
            chk("reinit_spike", spike_valid, 0);
        end
        run_steps(1, 1'b0, 0, '0, '0);
        chk("reinit_v5", obs_v5, 16'hECE1);
        chk("reinit_i3", obs_i3, 16'h0000);
        chk("reinit_steps", step_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
